// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: control-FSM states, major opcodes and
// the datapath select encodings used by the control unit and the ALU.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_LOAD_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RS1  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_STEP = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control: fetch/decode/execute/memory/writeback FSM
// driving datapath selects, write enables and the memory request handshake.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int PC_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       illegal
);

    // PC_STEP lives in the datapath; it only has to be a sane positive step here.
    generate
        if (PC_STEP <= 0) begin : g_bad_pc_step
        end
    endgenerate

    // The branch condition is applied in the datapath, not here.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    OP_LUI:             state_d = S_LUI;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI:  state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_LOAD_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JAL: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_comb begin
        alu_op        = ALU_ADD;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        pc_src        = PCSRC_ALU;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_STEP;
                // Mealy strobes; gated by rst_n so nothing loads while reset is held
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
            end
            S_DECODE:   alu_src_b = SRCB_IMM;
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_ALU_WB:   reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_LOAD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_src    = PCSRC_JUMP;
                reg_write = 1'b1;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output signatures for each
// instruction class, stalls, reset abort and the sticky illegal trap.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'h00;
    logic       mem_ready = 1'b0;
    logic       alu_zero = 1'b0;
    logic [1:0] alu_op, alu_src_a, alu_src_b, pc_src;
    logic       pc_write, pc_write_cond, i_or_d, mem_req, mem_we;
    logic       ir_write, reg_write, mem_to_reg, illegal;

    int tests = 0;
    int fails = 0;

    multicycle_control #(.PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_req(mem_req),
        .mem_we(mem_we), .ir_write(ir_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {alu_op, src_a, src_b, pc_src, pc_write, pc_write_cond, i_or_d, mem_req,
    //  mem_we, ir_write, reg_write, mem_to_reg}
    logic [15:0] sig;
    assign sig = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, pc_write_cond,
                  i_or_d, mem_req, mem_we, ir_write, reg_write, mem_to_reg};

    localparam logic [15:0] F_RDY  = 16'h0494;
    localparam logic [15:0] F_STL  = 16'h0410;
    localparam logic [15:0] DEC    = 16'h0800;
    localparam logic [15:0] EXR    = 16'h9000;
    localparam logic [15:0] EXI    = 16'h9800;
    localparam logic [15:0] AWB    = 16'h0002;
    localparam logic [15:0] MADDR  = 16'h1800;
    localparam logic [15:0] MRD    = 16'h0030;
    localparam logic [15:0] LWB    = 16'h0003;
    localparam logic [15:0] MWR    = 16'h0038;
    localparam logic [15:0] BRN    = 16'h5140;
    localparam logic [15:0] JL     = 16'h0282;
    localparam logic [15:0] LU     = 16'h2800;

    // Tasks are entered 1 time unit after a rising edge.
    task automatic drive(input logic [6:0] op, input logic rdy);
        opcode    = op;
        mem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state;
        mem_ready = 1'b1;
        #3;
        tests++;
        if (sig !== F_STL || illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: sig=%h illegal=%b expected sig=%h illegal=0", sig, illegal, F_STL);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype;
        logic [15:0] exp [5] = '{F_RDY, DEC, EXR, AWB, F_STL};
        logic        rdy [5] = '{1, 1, 1, 1, 0};
        int          rw = 0;
        for (int i = 0; i < 5; i++) begin
            drive(7'h33, rdy[i]);
            if (i < 4) rw += int'(reg_write);
            tests++;
            if (sig !== exp[i] || illegal !== 1'b0) begin
                fails++;
                $display("FAIL rtype cyc%0d: sig=%h expected %h", i, sig, exp[i]);
            end
            adv();
        end
        tests++;
        if (rw != 1) begin
            fails++;
            $display("FAIL rtype_reg_write_count: got %0d expected 1", rw);
        end
    endtask

    task automatic test_itype_opcode_ignored;
        logic [15:0] exp [5] = '{F_RDY, DEC, EXI, AWB, F_STL};
        logic [6:0]  op  [5] = '{7'h13, 7'h13, 7'h03, 7'h7F, 7'h63};
        logic        rdy [5] = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive(op[i], rdy[i]);
            tests++;
            if (sig !== exp[i] || illegal !== 1'b0) begin
                fails++;
                $display("FAIL itype cyc%0d: sig=%h expected %h", i, sig, exp[i]);
            end
            adv();
        end
    endtask

    task automatic test_load_stall;
        logic [15:0] exp [8] = '{F_RDY, DEC, MADDR, MRD, MRD, MRD, LWB, F_STL};
        logic        rdy [8] = '{1, 1, 1, 0, 0, 1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            drive(7'h03, rdy[i]);
            tests++;
            if (sig !== exp[i]) begin
                fails++;
                $display("FAIL load_stall cyc%0d: sig=%h expected %h", i, sig, exp[i]);
            end
            adv();
        end
    endtask

    task automatic test_store;
        logic [15:0] exp [5] = '{F_RDY, DEC, MADDR, MWR, F_STL};
        for (int i = 0; i < 5; i++) begin
            drive(7'h23, i < 4);
            tests++;
            if (sig !== exp[i]) begin
                fails++;
                $display("FAIL store cyc%0d: sig=%h expected %h", i, sig, exp[i]);
            end
            adv();
        end
    endtask

    task automatic test_branch;
        logic [15:0] exp [4] = '{F_RDY, DEC, BRN, F_STL};
        int          rw = 0;
        for (int i = 0; i < 4; i++) begin
            alu_zero = i[0];
            drive(7'h63, i < 3);
            rw += int'(reg_write);
            tests++;
            if (sig !== exp[i]) begin
                fails++;
                $display("FAIL branch cyc%0d: sig=%h expected %h", i, sig, exp[i]);
            end
            adv();
        end
        tests++;
        if (rw != 0) begin
            fails++;
            $display("FAIL branch_reg_write: got %0d cycles expected 0", rw);
        end
    endtask

    task automatic test_jal_lui;
        logic [15:0] exp [9] = '{F_RDY, DEC, JL, F_RDY, DEC, LU, AWB, F_STL, F_STL};
        logic [6:0]  op  [9] = '{7'h6F, 7'h6F, 7'h6F, 7'h37, 7'h37, 7'h37, 7'h37, 7'h37, 7'h37};
        for (int i = 0; i < 9; i++) begin
            drive(op[i], i < 7);
            tests++;
            if (sig !== exp[i]) begin
                fails++;
                $display("FAIL jal_lui cyc%0d: sig=%h expected %h", i, sig, exp[i]);
            end
            adv();
        end
    endtask

    task automatic test_fetch_stall;
        logic [15:0] exp [7] = '{F_STL, F_STL, F_STL, F_RDY, DEC, JL, F_STL};
        logic        rdy [7] = '{0, 0, 0, 1, 1, 1, 0};
        int          pulses = 0;
        for (int i = 0; i < 7; i++) begin
            drive(7'h6F, rdy[i]);
            if (i < 4) pulses += int'(ir_write & pc_write);
            tests++;
            if (sig !== exp[i]) begin
                fails++;
                $display("FAIL fetch_stall cyc%0d: sig=%h expected %h", i, sig, exp[i]);
            end
            adv();
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL fetch_stall_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_reset_mid_store;
        logic [15:0] exp [5] = '{F_RDY, DEC, MADDR, MWR, MWR};
        logic        rdy [5] = '{1, 1, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(7'h23, rdy[i]);
            tests++;
            if (sig !== exp[i]) begin
                fails++;
                $display("FAIL reset_mid_store cyc%0d: sig=%h expected %h", i, sig, exp[i]);
            end
            if (i < 4) adv();
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (sig !== F_STL || mem_we !== 1'b0 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: sig=%h mem_we=%b illegal=%b expected sig=%h", sig, mem_we, illegal, F_STL);
        end
        mem_ready = 1'b1;
        #1;
        tests++;
        if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_req !== 1'b1) begin
            fails++;
            $display("FAIL reset_strobes: ir_write=%b pc_write=%b mem_req=%b expected 0 0 1", ir_write, pc_write, mem_req);
        end
        adv();
        tests++;
        if (sig !== F_STL) begin
            fails++;
            $display("FAIL reset_held_edge: sig=%h expected %h", sig, F_STL);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_illegal;
        int bad = 0;
        drive(7'h7F, 1'b1);
        tests++;
        if (sig !== F_RDY) begin
            fails++;
            $display("FAIL illegal_fetch: sig=%h expected %h", sig, F_RDY);
        end
        adv();
        drive(7'h7F, 1'b1);
        tests++;
        if (sig !== DEC || illegal !== 1'b0) begin
            fails++;
            $display("FAIL illegal_decode: sig=%h illegal=%b expected sig=%h illegal=0", sig, illegal, DEC);
        end
        adv();
        for (int i = 0; i < 20; i++) begin
            drive(7'(i * 13), 1'($urandom_range(0, 1)));
            if (sig !== 16'h0000 || illegal !== 1'b1) bad++;
            adv();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL illegal_sticky: %0d bad cycles expected 0", bad);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (illegal !== 1'b0 || sig !== F_STL) begin
            fails++;
            $display("FAIL illegal_reset: illegal=%b sig=%h expected 0 %h", illegal, sig, F_STL);
        end
        adv();
        rst_n = 1'b1;
        drive(7'h33, 1'b0);
        tests++;
        if (illegal !== 1'b0 || sig !== F_STL) begin
            fails++;
            $display("FAIL illegal_after_reset: illegal=%b sig=%h expected 0 %h", illegal, sig, F_STL);
        end
        adv();
    endtask

    initial begin
        test_reset_state();
        test_rtype();
        test_itype_opcode_ignored();
        test_load_stall();
        test_store();
        test_branch();
        test_jal_lui();
        test_fetch_stall();
        test_reset_mid_store();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
